// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction fetch stage:
// fetch FSM states, the NOP encoding and the default reset PC.
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      GAP   = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] INST_NOP        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_PC_ADDR = 32'h8000_0000;

   // Even parity over an instruction word, available for datapath protection.
   function automatic logic word_parity(input logic [31:0] word);
      word_parity = ^word;
   endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: Wishbone master that fetches one word per bus cycle
// into the IF/ID register, with stall buffering and branch redirect/kill.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = ADDR_WIDTH'(DEFAULT_PC_ADDR),
   parameter int                    DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  use_branch,
   input  logic [ADDR_WIDTH-1:0] branch_out,
   input  logic                  stall,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic                  wb_we_o,
   output logic [3:0]            wb_sel_o,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   input  logic                  wb_ack_i,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   output logic [ADDR_WIDTH-1:0] id_pc,
   output logic [DATA_WIDTH-1:0] id_inst,
   output logic                  id_valid
);

   localparam logic [DATA_WIDTH-1:0] NOP    = DATA_WIDTH'(INST_NOP);
   localparam logic [ADDR_WIDTH-1:0] PC_INC = ADDR_WIDTH'(32'd4);

   fetch_state_t          state;
   fetch_state_t          state_next;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic                  kill;
   logic                  kill_next;
   logic [ADDR_WIDTH-1:0] kill_target;
   logic [ADDR_WIDTH-1:0] kill_target_next;
   logic [DATA_WIDTH-1:0] buf_inst;
   logic [DATA_WIDTH-1:0] buf_inst_next;
   logic [ADDR_WIDTH-1:0] buf_pc;
   logic [ADDR_WIDTH-1:0] buf_pc_next;
   logic [ADDR_WIDTH-1:0] id_pc_next;
   logic [DATA_WIDTH-1:0] id_inst_next;
   logic                  id_valid_next;
   logic                  deliver;
   logic [DATA_WIDTH-1:0] deliver_inst;
   logic [ADDR_WIDTH-1:0] deliver_pc;
   logic [ADDR_WIDTH-1:0] branch_target;
   logic                  unused_branch_low;

   // Low address bits of a redirect are dropped; fetches are always word aligned.
   assign branch_target     = {branch_out[ADDR_WIDTH-1:2], 2'b00};
   assign unused_branch_low = ^branch_out[1:0];

   assign wb_cyc_o = (state == FETCH) && !reset;
   assign wb_stb_o = (state == FETCH) && !reset;
   assign wb_we_o  = 1'b0;
   assign wb_sel_o = 4'b1111;
   assign wb_adr_o = {pc[ADDR_WIDTH-1:2], 2'b00};

   // State, PC, kill and buffer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= FETCH;
         pc          <= PC_ADDR;
         kill        <= 1'b0;
         kill_target <= '0;
         buf_inst    <= '0;
         buf_pc      <= '0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         kill        <= kill_next;
         kill_target <= kill_target_next;
         buf_inst    <= buf_inst_next;
         buf_pc      <= buf_pc_next;
      end
   end

   // IF/ID output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_pc    <= PC_ADDR;
         id_inst  <= NOP;
         id_valid <= 1'b0;
      end else begin
         id_pc    <= id_pc_next;
         id_inst  <= id_inst_next;
         id_valid <= id_valid_next;
      end
   end

   // Next-state logic for the fetch FSM, PC, kill tracking and holding buffer.
   always_comb begin
      state_next       = state;
      pc_next          = pc;
      kill_next        = kill;
      kill_target_next = kill_target;
      buf_inst_next    = buf_inst;
      buf_pc_next      = buf_pc;
      deliver          = 1'b0;
      deliver_inst     = buf_inst;
      deliver_pc       = buf_pc;

      case (state)
         FETCH: begin
            if (wb_ack_i) begin
               kill_next  = 1'b0;
               state_next = GAP;
               // A redirect seen now or earlier in this bus cycle discards the data.
               if (use_branch) begin
                  pc_next = branch_target;
               end else if (kill) begin
                  pc_next = kill_target;
               end else if (!stall) begin
                  deliver      = 1'b1;
                  deliver_inst = wb_dat_i;
                  deliver_pc   = pc;
                  pc_next      = pc + PC_INC;
               end else begin
                  buf_inst_next = wb_dat_i;
                  buf_pc_next   = pc;
                  pc_next       = pc + PC_INC;
                  state_next    = HOLD;
               end
            end else if (use_branch) begin
               // Address must stay stable until ack, so the redirect is deferred.
               kill_next        = 1'b1;
               kill_target_next = branch_target;
            end else begin
               state_next = FETCH;
            end
         end
         HOLD: begin
            if (use_branch) begin
               pc_next       = branch_target;
               buf_inst_next = '0;
               buf_pc_next   = '0;
               state_next    = GAP;
            end else if (!stall) begin
               deliver       = 1'b1;
               buf_inst_next = '0;
               buf_pc_next   = '0;
               state_next    = GAP;
            end else begin
               state_next = HOLD;
            end
         end
         GAP: begin
            state_next = FETCH;
            if (use_branch) begin
               pc_next = branch_target;
            end else begin
               pc_next = pc;
            end
         end
         default: begin
            state_next = FETCH;
            kill_next  = 1'b0;
         end
      endcase
   end

   // IF/ID next value: redirect flushes, stall holds, otherwise deliver or bubble.
   always_comb begin
      id_pc_next    = id_pc;
      id_inst_next  = id_inst;
      id_valid_next = id_valid;
      if (use_branch) begin
         id_inst_next  = NOP;
         id_valid_next = 1'b0;
      end else if (stall) begin
         id_valid_next = id_valid;
      end else if (deliver) begin
         id_pc_next    = deliver_pc;
         id_inst_next  = deliver_inst;
         id_valid_next = 1'b1;
      end else begin
         id_inst_next  = NOP;
         id_valid_next = 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue-based reference model is compared on
// every falling edge, plus literal expectations for each scenario.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam logic [31:0] PC0  = 32'h8000_0000;
   localparam logic [31:0] NOPW = 32'h0000_0013;
   localparam logic [31:0] MASK = 32'hFFFF_FFFC;

   logic        clk;
   logic        reset;
   logic        use_branch;
   logic [31:0] branch_out;
   logic        stall;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_adr_o;
   logic        wb_ack_i;
   logic [31:0] wb_dat_i;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;

   int checks = 0;
   int errors = 0;

   fetch_stage #(.ADDR_WIDTH(32), .PC_ADDR(PC0), .DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .use_branch(use_branch), .branch_out(branch_out),
      .stall(stall), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_ack_i(wb_ack_i),
      .wb_dat_i(wb_dat_i), .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model: the fetch unit is either on the bus, holding a word
   // for decode, or in its one idle slot; redirects during a bus cycle queue up.
   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } slot_t;

   slot_t       held_q[$];
   logic [31:0] redirect_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_id_pc;
   logic [31:0] m_id_inst;
   logic        m_id_valid;
   logic        m_on_bus;

   always @(posedge clk or posedge reset) begin : ref_model
      logic        give;
      logic [31:0] g_inst;
      logic [31:0] g_pc;
      slot_t       s;
      if (reset) begin
         m_pc       = PC0;
         m_on_bus   = 1'b1;
         held_q.delete();
         redirect_q.delete();
         m_id_valid = 1'b0;
         m_id_pc    = PC0;
         m_id_inst  = NOPW;
      end else begin
         give   = 1'b0;
         g_inst = 32'h0;
         g_pc   = 32'h0;
         if (m_on_bus) begin
            if (wb_ack_i) begin
               m_on_bus = 1'b0;
               if (use_branch) m_pc = branch_out & MASK;
               else if (redirect_q.size() != 0) m_pc = redirect_q[$];
               else if (!stall) begin
                  give = 1'b1; g_inst = wb_dat_i; g_pc = m_pc; m_pc = m_pc + 32'd4;
               end else begin
                  s.inst = wb_dat_i; s.pc = m_pc; held_q.push_back(s); m_pc = m_pc + 32'd4;
               end
               redirect_q.delete();
            end else if (use_branch) begin
               redirect_q.push_back(branch_out & MASK);
            end
         end else if (held_q.size() != 0) begin
            if (use_branch) begin
               held_q.delete();
               m_pc = branch_out & MASK;
            end else if (!stall) begin
               give = 1'b1; g_inst = held_q[0].inst; g_pc = held_q[0].pc;
               held_q.delete();
            end
         end else begin
            if (use_branch) m_pc = branch_out & MASK;
            m_on_bus = 1'b1;
         end
         if (use_branch) begin
            m_id_valid = 1'b0; m_id_inst = NOPW;
         end else if (!stall) begin
            if (give) begin
               m_id_valid = 1'b1; m_id_inst = g_inst; m_id_pc = g_pc;
            end else begin
               m_id_valid = 1'b0; m_id_inst = NOPW;
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("cyc", {31'b0, wb_cyc_o}, {31'b0, m_on_bus && !reset});
      chk("stb", {31'b0, wb_stb_o}, {31'b0, m_on_bus && !reset});
      chk("we", {31'b0, wb_we_o}, 32'h0);
      chk("sel", {28'b0, wb_sel_o}, 32'h0000_000F);
      if (m_on_bus && !reset) chk("adr", wb_adr_o, m_pc & MASK);
      chk("id_valid", {31'b0, id_valid}, {31'b0, m_id_valid});
      chk("id_pc", id_pc, m_id_pc);
      chk("id_inst", id_inst, m_id_inst);
   end

   task automatic step(input logic a, input logic [31:0] d, input logic ub,
                       input logic [31:0] bo, input logic st);
      wb_ack_i   = a;
      wb_dat_i   = d;
      use_branch = ub;
      branch_out = bo;
      stall      = st;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; use_branch = 1'b0; branch_out = 32'h0; stall = 1'b0;
      wb_ack_i = 1'b0; wb_dat_i = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cyc", {31'b0, wb_cyc_o}, 32'h0);
      chk("rst_valid", {31'b0, id_valid}, 32'h0);
      chk("rst_id_pc", id_pc, 32'h8000_0000);
      chk("rst_id_inst", id_inst, 32'h0000_0013);
      reset = 1'b0;
      #1;
      chk("rel_cyc", {31'b0, wb_cyc_o}, 32'h1);
      chk("rel_adr", wb_adr_o, 32'h8000_0000);

      // One wait cycle, then ack with an addi.
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h0000_0093, 1'b0, 32'h0, 1'b0);
      chk("s1_id_pc", id_pc, 32'h8000_0000);
      chk("s1_id_inst", id_inst, 32'h0000_0093);
      chk("s1_valid", {31'b0, id_valid}, 32'h1);
      chk("s1_gap_cyc", {31'b0, wb_cyc_o}, 32'h0);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("s1_next_adr", wb_adr_o, 32'h8000_0004);
      chk("s1_hold_valid", {31'b0, id_valid}, 32'h1);

      // Stall at ack: word buffered, released three cycles later.
      step(1'b1, 32'h0010_0113, 1'b0, 32'h0, 1'b1);
      chk("s2_hold_inst", id_inst, 32'h0000_0093);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("s2_hold_inst2", id_inst, 32'h0000_0093);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("s2_id_pc", id_pc, 32'h8000_0004);
      chk("s2_id_inst", id_inst, 32'h0010_0113);
      chk("s2_valid", {31'b0, id_valid}, 32'h1);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("s2_next_adr", wb_adr_o, 32'h8000_0008);

      // Redirect two cycles before ack: data discarded.
      step(1'b0, 32'h0, 1'b1, 32'h8000_0100, 1'b0);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
      chk("s3_valid", {31'b0, id_valid}, 32'h0);
      chk("s3_id_inst", id_inst, 32'h0000_0013);
      chk("s3_id_pc", id_pc, 32'h8000_0004);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("s3_adr", wb_adr_o, 32'h8000_0100);

      // Redirect coincident with ack while stalled.
      step(1'b1, 32'h0000_0113, 1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("s4_pre_valid", {31'b0, id_valid}, 32'h1);
      step(1'b1, 32'h1234_5678, 1'b1, 32'h8000_0040, 1'b1);
      chk("s4_valid", {31'b0, id_valid}, 32'h0);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("s4_adr", wb_adr_o, 32'h8000_0040);

      // Two redirects in one bus cycle: last wins, low bits ignored.
      step(1'b0, 32'h0, 1'b1, 32'h8000_0200, 1'b0);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 32'h8000_0303, 1'b0);
      step(1'b1, 32'hCAFE_BABE, 1'b0, 32'h0, 1'b0);
      chk("s5_valid", {31'b0, id_valid}, 32'h0);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("s5_adr", wb_adr_o, 32'h8000_0300);

      // Redirect while holding a buffered word.
      step(1'b1, 32'hAAAA_0013, 1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 32'h8000_0500, 1'b1);
      chk("s6_valid", {31'b0, id_valid}, 32'h0);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("s6_adr", wb_adr_o, 32'h8000_0500);

      // Redirect in the gap slot to the top of memory, then PC wrap.
      step(1'b1, 32'h0000_0213, 1'b0, 32'h0, 1'b0);
      chk("s7_id_pc", id_pc, 32'h8000_0500);
      step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      chk("s7_adr", wb_adr_o, 32'hFFFF_FFFC);
      step(1'b1, 32'h0000_0313, 1'b0, 32'h0, 1'b0);
      chk("s7_wrap_id_pc", id_pc, 32'hFFFF_FFFC);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("s7_wrap_adr", wb_adr_o, 32'h0000_0000);

      // Reset asserted in the middle of a bus cycle.
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("s8_cyc", {31'b0, wb_cyc_o}, 32'h0);
      chk("s8_stb", {31'b0, wb_stb_o}, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("s8_adr", wb_adr_o, 32'h8000_0000);
      chk("s8_rel_cyc", {31'b0, wb_cyc_o}, 32'h1);
      chk("s8_id_inst", id_inst, 32'h0000_0013);
      step(1'b1, 32'h0000_0413, 1'b0, 32'h0, 1'b0);
      chk("s8_id_pc", id_pc, 32'h8000_0000);
      chk("s8_id_inst2", id_inst, 32'h0000_0413);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_ADDR, default 32'h8000_0000: reset PC and first fetch address.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: PC and bus address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: instruction and bus data width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port use_branch, input, 1: redirect request from the branch stage.
REQ-007 SHALL have port branch_out, input, ADDR_WIDTH: redirect target, valid when use_branch=1.
REQ-008 SHALL have port stall, input, 1: decode cannot accept; hold the IF/ID outputs.
REQ-009 SHALL have Wishbone master outputs wb_cyc_o (1), wb_stb_o (1), wb_we_o (1, constant 0), wb_sel_o (4, constant 4'b1111) and wb_adr_o (ADDR_WIDTH).
REQ-010 SHALL have Wishbone master inputs wb_ack_i (1) and wb_dat_i (DATA_WIDTH).
REQ-011 SHALL have outputs id_pc (ADDR_WIDTH), id_inst (DATA_WIDTH) and id_valid (1): the IF/ID register.

Function
REQ-012 SHALL implement FSM states FETCH (cyc=stb=1), GAP (cyc=stb=0 for exactly one cycle) and HOLD (instruction buffered, cyc=stb=0).
REQ-013 SHALL drive wb_adr_o = {pc[ADDR_WIDTH-1:2], 2'b00}, held stable throughout FETCH until ack.
REQ-014 SHALL, in FETCH with ack, no use_branch and no pending kill, and stall=0: load id_inst=wb_dat_i, id_pc=pc and id_valid=1, set pc=pc+4 (modulo 2^ADDR_WIDTH) and go to GAP.
REQ-015 SHALL, in FETCH with ack, no use_branch and no pending kill, and stall=1: latch wb_dat_i and pc into a holding buffer, set pc=pc+4 and go to HOLD.
REQ-016 SHALL, in HOLD with stall=0: move the buffer into the IF/ID register with id_valid=1 and go to GAP.
REQ-017 SHALL, in GAP: go to FETCH on the next cycle.
REQ-018 SHALL keep id_pc, id_inst and id_valid unchanged while stall=1 and use_branch=0.
REQ-019 SHALL, when stall=0 and no instruction is delivered in a cycle, set id_valid=0 and id_inst=32'h0000_0013 (NOP).
REQ-020 SHALL give use_branch priority over stall: on the next edge, id_valid=0, id_inst=NOP and pc=branch_out.
REQ-021 SHALL, on use_branch in FETCH without ack: set a kill flag and save the target; the in-flight bus cycle completes, its ack data is discarded, pc=target, then GAP.
REQ-022 SHALL, on use_branch in the same cycle as ack: discard the data, set pc=branch_out and go to GAP.
REQ-023 SHALL, on use_branch in HOLD: drop the buffer, set pc=branch_out and go to GAP.
REQ-024 SHALL let a later use_branch while kill is pending overwrite the saved target (last wins).
REQ-025 SHALL ignore branch_out[1:0] for addressing.
REQ-026 SHALL reach a minimum fetch period of 2 cycles (FETCH with ack, then GAP).

Reset
REQ-027 SHALL, while reset=1: set pc=PC_ADDR, state=FETCH, kill=0, buffer cleared, id_valid=0, id_pc=PC_ADDR and id_inst=NOP.
REQ-028 SHALL drive wb_cyc_o=wb_stb_o=0 while reset=1, including mid-bus-cycle; after release, the first cycle asserts cyc/stb with adr=PC_ADDR.

Structure
REQ-029 SHALL take the state enum, the INST_NOP constant and the default PC_ADDR from the shared pipeline package.
REQ-030 SHALL be a single module with no sub-module; the holding buffer is internal registers.

Verification
REQ-031 SHALL cover: reset release, ack after 1 wait cycle returning 32'h0000_0093 -> adr 8000_0000, then id_pc=8000_0000, id_inst=0000_0093, id_valid=1, next adr 8000_0004.
REQ-032 SHALL cover: stall=1 at ack -> HOLD, id outputs unchanged; stall drops 3 cycles later -> buffered instruction appears with id_valid=1.
REQ-033 SHALL cover: use_branch=1 with branch_out=8000_0100 two cycles before ack -> ack data discarded, id_valid=0, next fetch adr 8000_0100.
REQ-034 SHALL cover: use_branch coincident with ack and stall=1 -> id_valid=0, next adr = target.
REQ-035 SHALL cover: two use_branch pulses (targets 8000_0200, then 8000_0300) during one fetch -> next adr 8000_0300.
REQ-036 SHALL cover: reset asserted mid-FETCH -> cyc/stb=0 immediately; after release, adr=8000_0000.
